// File: rtl/nes_pad_pkg.sv
`default_nettype none
// ============================================================================
// nes_pad_pkg : shared button indices, state encoding and sizing constants
// Rev 1.0
// ============================================================================
package nes_pad_pkg;

  localparam int NUM_BUTTONS = 8;

  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LATCH = 3'd1,
    LOW   = 3'd2,
    HIGH  = 3'd3,
    DONE  = 3'd4
  } pad_state_e;

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
// sync_2ff : single-bit two-flop synchronizer with configurable reset value
// Rev 1.0
// ============================================================================
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_async,
  output logic o_sync
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

endmodule
`default_nettype wire

// File: rtl/nes_pad_reader.sv
`default_nettype none
// ============================================================================
// nes_pad_reader : polls an NES pad (latch + 8 clocked bits), publishes buttons
// Rev 1.0
// ============================================================================
module nes_pad_reader
  import nes_pad_pkg::*;
#(
  parameter int HALF_CYC = 300,
  parameter int POLL_CYC = 833333
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   poll_req,
  input  logic                   pad_data,
  output logic                   pad_latch,
  output logic                   pad_clk,
  output logic [NUM_BUTTONS-1:0] buttons,
  output logic                   valid,
  output logic                   busy
);

  localparam int PH_W   = $clog2(2 * HALF_CYC);
  localparam int POLL_W = (POLL_CYC > 1) ? $clog2(POLL_CYC) : 1;
  localparam int IDX_W  = $clog2(NUM_BUTTONS);

  localparam logic [PH_W-1:0]   c_LATCH_LAST = PH_W'(2 * HALF_CYC - 1);
  localparam logic [PH_W-1:0]   c_HALF_LAST  = PH_W'(HALF_CYC - 1);
  localparam logic [PH_W-1:0]   c_PH_ONE     = PH_W'(1);
  localparam logic [POLL_W-1:0] c_POLL_LAST  = POLL_W'(POLL_CYC - 1);
  localparam logic [POLL_W-1:0] c_POLL_ONE   = POLL_W'(1);
  localparam logic [IDX_W-1:0]  c_IDX_LAST   = IDX_W'(BTN_RIGHT);
  localparam logic [IDX_W-1:0]  c_IDX_ONE    = IDX_W'(1);

  pad_state_e             r_state;
  pad_state_e             w_state_nxt;
  logic [PH_W-1:0]        r_phase;
  logic [POLL_W-1:0]      r_poll_cnt;
  logic [IDX_W-1:0]       r_bit_idx;
  logic [NUM_BUTTONS-1:0] r_shift;
  logic [NUM_BUTTONS-1:0] w_shift_nxt;
  logic [NUM_BUTTONS-1:0] r_buttons;
  logic                   w_pad_sync;
  logic                   w_sample;
  logic                   w_phase_end;

  sync_2ff #(
    .RESET_VAL (1'b1)
  ) u_sync_data (
    .clk     (clk),
    .rst     (reset),
    .i_async (pad_data),
    .o_sync  (w_pad_sync)
  );

  assign w_phase_end = (r_phase == c_HALF_LAST);
  assign w_sample    = (r_state == LOW) && w_phase_end;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:  if (poll_req || (r_poll_cnt == c_POLL_LAST)) w_state_nxt = LATCH;
      LATCH: if (r_phase == c_LATCH_LAST) w_state_nxt = LOW;
      LOW:   if (w_phase_end) w_state_nxt = (r_bit_idx == c_IDX_LAST) ? DONE : HIGH;
      HIGH:  if (w_phase_end) w_state_nxt = LOW;
      DONE:  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Pad drives active-low data; store it as active-high "pressed".
  always_comb begin
    w_shift_nxt            = r_shift;
    w_shift_nxt[r_bit_idx] = ~w_pad_sync;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_phase    <= '0;
      r_poll_cnt <= '0;
      r_bit_idx  <= '0;
      r_shift    <= '0;
      r_buttons  <= '0;
    end else begin
      r_state <= w_state_nxt;

      if ((w_state_nxt != r_state) || (r_state == IDLE) || (r_state == DONE)) begin
        r_phase <= '0;
      end else begin
        r_phase <= r_phase + c_PH_ONE;
      end

      if ((r_state == IDLE) && (w_state_nxt == IDLE)) begin
        r_poll_cnt <= r_poll_cnt + c_POLL_ONE;
      end else begin
        r_poll_cnt <= '0;
      end

      if (r_state == LATCH) begin
        r_bit_idx <= '0;
      end else if ((r_state == HIGH) && w_phase_end) begin
        r_bit_idx <= r_bit_idx + c_IDX_ONE;
      end

      // The last sample publishes the whole frame at once, so buttons and valid align.
      if (w_sample) begin
        r_shift <= w_shift_nxt;
        if (r_bit_idx == c_IDX_LAST) begin
          r_buttons <= w_shift_nxt;
        end
      end
    end
  end

  assign pad_latch = (r_state == LATCH);
  assign pad_clk   = (r_state == HIGH);
  assign valid     = (r_state == DONE);
  assign busy      = (r_state != IDLE);
  assign buttons   = r_buttons;

endmodule
`default_nettype wire

// File: tb/tb_nes_pad_reader.sv
`default_nettype none
// ============================================================================
// tb_nes_pad_reader : directed bench with a behavioural NES pad model
// Rev 1.0
// ============================================================================
module tb_nes_pad_reader;

  localparam int H      = 4;
  localparam int P      = 200;
  localparam int FRAME  = 17 * H;
  localparam int PERIOD = 17 * H + 1 + P;

  logic       clk = 1'b0;
  logic       reset;
  logic       poll_req;
  logic       pad_data;
  logic       pad_latch;
  logic       pad_clk;
  logic [7:0] buttons;
  logic       valid;
  logic       busy;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [7:0] pad_pattern;
  logic [7:0] pad_sr = 8'h00;
  logic       pad_clk_q = 1'b0;
  logic       unplugged;

  nes_pad_reader #(
    .HALF_CYC (H),
    .POLL_CYC (P)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .poll_req  (poll_req),
    .pad_data  (pad_data),
    .pad_latch (pad_latch),
    .pad_clk   (pad_clk),
    .buttons   (buttons),
    .valid     (valid),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // 4021-style pad: parallel load while latched, shift on pad_clk rise.
  always @(posedge clk) begin
    if (pad_latch === 1'b1) pad_sr <= pad_pattern;
    else if (pad_clk === 1'b1 && pad_clk_q === 1'b0) pad_sr <= {1'b0, pad_sr[7:1]};
    pad_clk_q <= pad_clk;
  end

  assign pad_data = unplugged ? 1'b1 : ~pad_sr[0];

  int   rise_last = -1;
  int   rise_prev = -1;
  logic latch_d   = 1'b0;
  always @(negedge clk) begin
    if (pad_latch === 1'b1 && latch_d === 1'b0) begin
      rise_prev = rise_last;
      rise_last = cyc;
    end
    latch_d = pad_latch;
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic pulse_poll();
    poll_req = 1'b1;
    @(negedge clk);
    poll_req = 1'b0;
  endtask

  task automatic wait_latch(input string tag);
    int k = 0;
    while (pad_latch !== 1'b1 && k < 400) begin
      @(negedge clk);
      k++;
    end
    chk1({tag, "/latch_seen"}, (k < 400), 1'b1);
  endtask

  // Walks one frame from latch rise (cycle 0) through the first IDLE cycle.
  task automatic check_frame(input string tag, input logic [7:0] exp, input logic [7:0] prev,
                             input int poll_at, input int chg_at, input logic [7:0] chg_val);
    int   edges = 0;
    logic pd    = 1'b0;
    logic exp_clk;
    wait_latch(tag);
    for (int c = 0; c <= FRAME; c++) begin
      exp_clk = (c >= 2 * H) && (c < FRAME) && ((((c - 2 * H) / H) % 2) == 1);
      chk1({tag, "/latch"}, pad_latch, (c < 2 * H));
      chk1({tag, "/pclk"}, pad_clk, exp_clk);
      chk1({tag, "/valid"}, valid, (c == FRAME));
      chk1({tag, "/busy"}, busy, 1'b1);
      chk8({tag, "/buttons"}, buttons, (c == FRAME) ? exp : prev);
      if (pad_clk === 1'b1 && pd === 1'b0) edges++;
      pd = pad_clk;
      poll_req = (c == poll_at);
      if (c == chg_at) pad_pattern = chg_val;
      @(negedge clk);
    end
    poll_req = 1'b0;
    chk1({tag, "/valid_end"}, valid, 1'b0);
    chk1({tag, "/busy_end"}, busy, 1'b0);
    chk8({tag, "/buttons_end"}, buttons, exp);
    chk_int({tag, "/pclk_edges"}, edges, 7);
  endtask

  int t0;

  initial begin
    reset       = 1'b1;
    poll_req    = 1'b0;
    unplugged   = 1'b1;
    pad_pattern = 8'h00;
    repeat (5) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk1("rst/latch", pad_latch, 1'b0);
    chk1("rst/pclk", pad_clk, 1'b0);
    chk8("rst/buttons", buttons, 8'h00);
    chk1("rst/valid", valid, 1'b0);
    chk1("rst/busy", busy, 1'b0);
    repeat (100) @(negedge clk);
    chk1("idle/busy", busy, 1'b0);
    chk1("idle/latch", pad_latch, 1'b0);

    // A + Start on demand
    unplugged   = 1'b0;
    pad_pattern = 8'h09;
    pulse_poll();
    check_frame("a_start", 8'h09, 8'h00, -1, -1, 8'h00);

    // unplugged pad reads as nothing pressed
    unplugged = 1'b1;
    pulse_poll();
    check_frame("unplugged", 8'h00, 8'h09, -1, -1, 8'h00);

    // poll_req mid-frame is dropped; next poll comes from the counter
    unplugged   = 1'b0;
    pad_pattern = 8'h09;
    pulse_poll();
    check_frame("mid_req", 8'h09, 8'h00, 20, -1, 8'h00);
    t0 = rise_last;
    pad_pattern = 8'h06;
    check_frame("after_req", 8'h06, 8'h09, -1, -1, 8'h00);
    chk_int("mid_req/period", rise_last - t0, PERIOD);

    // async reset during LOW(4) of a Right+Up frame
    pad_pattern = 8'h90;
    pulse_poll();
    wait_latch("rst_mid");
    repeat (41) @(negedge clk);
    chk8("rst_mid/buttons_before", buttons, 8'h06);
    reset = 1'b1;
    #1;
    chk1("rst_mid/latch", pad_latch, 1'b0);
    chk1("rst_mid/pclk", pad_clk, 1'b0);
    chk8("rst_mid/buttons", buttons, 8'h00);
    chk1("rst_mid/busy", busy, 1'b0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    pulse_poll();
    check_frame("post_rst", 8'h90, 8'h00, -1, -1, 8'h00);
    t0 = rise_last;

    // free-running; pattern changes mid-frame must not leak into buttons
    pad_pattern = 8'h42;
    check_frame("free1", 8'h42, 8'h90, -1, 30, 8'hA5);
    chk_int("free1/period", rise_last - t0, PERIOD);
    t0 = rise_last;
    check_frame("free2", 8'hA5, 8'h42, -1, -1, 8'h00);
    chk_int("free2/period", rise_last - t0, PERIOD);
    t0 = rise_last;
    pad_pattern = 8'h81;
    check_frame("free3", 8'h81, 8'hA5, -1, 40, 8'hFF);
    chk_int("free3/period", rise_last - t0, PERIOD);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/nes_pad_reader.md
Name: nes_pad_reader

Overview:
- Reads a standard NES controller over its 3-wire serial interface and produces the 8-bit active-high `buttons` vector consumed by the button display and the CPU input ports.
- Polls periodically, or immediately on `poll_req`: one latch pulse, then clocks out 8 bits.
- Synchronizes the pad's data line and publishes each completed frame atomically with a one-cycle `valid` strobe.

Parameters:
- HALF_CYC, 300, clk cycles per pad-clock half period (6 us at 50 MHz); must be ≥ 4.
- POLL_CYC, 833333, idle cycles between polls (60 Hz at 50 MHz); must be ≥ 1.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- poll_req  in  1  request an immediate poll; honoured only in IDLE
- pad_data  in  1  serial data from the pad, asynchronous, active-low (0 = pressed)
- pad_latch  out  1  latch/strobe to the pad, active-high
- pad_clk  out  1  shift clock to the pad; idles low
- buttons  out  8  [0]=A [1]=B [2]=Select [3]=Start [4]=Up [5]=Down [6]=Left [7]=Right; 1 = pressed
- valid  out  1  single-cycle pulse when `buttons` has just been updated
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset values:
  - all outputs 0;
  - state IDLE; poll counter 0; shift register 0; synchronizer flops 1 (released).
- Reset is asynchronous. Asserting it mid-transfer forces pad_latch = pad_clk = 0 and buttons = 0 immediately.
- pad_data passes through a 2-FF synchronizer. Only the synchronized value is sampled.
- States: IDLE → LATCH → LOW → HIGH → … → LOW → DONE → IDLE.
- IDLE:
  - The poll counter increments each cycle.
  - Leave for LATCH when the counter reaches POLL_CYC-1, or when poll_req=1, whichever comes first.
  - The counter clears on leaving IDLE.
  - Cycle 0 is defined as the first LATCH cycle.
- LATCH:
  - pad_latch=1 for 2*HALF_CYC cycles (cycles 0 .. 2H-1), with pad_clk=0.
  - Bit index i ← 0.
- LOW(i):
  - pad_clk=0 for H cycles.
  - On the last cycle, invert the synchronized data into shift bit i.
  - Bit i is therefore sampled at cycle 2H + 2iH + H - 1.
- HIGH(i):
  - pad_clk=1 for H cycles (the rising edge shifts the pad); then i++ and go to LOW.
  - HIGH is skipped after i=7, so exactly 7 pad_clk rising edges occur per frame.
- DONE:
  - Occupies cycle 17H (one cycle).
  - buttons ← shift register; valid=1 for this cycle only.
  - Next cycle → IDLE.
- Per-poll timing:
  - valid fires exactly 17H cycles after pad_latch rises.
  - Under free-running polling, pad_latch rising edges are 17H + 1 + POLL_CYC cycles apart.
- buttons holds its previous frame throughout a transfer; it is never partially updated.
- poll_req outside IDLE is ignored, not queued. poll_req on the same cycle the counter expires starts a single poll.
- An unplugged pad (data pulled high) reads as 8'h00.
- Counters are sized by $clog2 of their parameter. The phase counter is shared by LATCH, LOW and HIGH and reloads on every state change.

Decomposition:
- nes_pad_pkg holds:
  - BTN_A..BTN_RIGHT index localparams (0..7);
  - the state enum typedef (IDLE, LATCH, LOW, HIGH, DONE);
  - the NUM_BUTTONS = 8 constant.
- One sub-module: sync_2ff (1-bit synchronizer, reset value 1), also reusable for the second pad port.

Test Plan (H=4, POLL_CYC=200, behavioural pad = 8-bit shift register: loads on pad_latch, shifts on pad_clk rise, drives ~bit):
- Reset held for 5 cycles, then released, with pad_data=1 → pad_latch, pad_clk, buttons, valid and busy all 0 until the first poll.
- poll_req in IDLE; pad holds A+Start pressed → pad_latch high for cycles 0–7; 7 pad_clk rising edges; buttons=8'h09 and valid=1 at cycle 68 only.
- pad_data tied to 1 (unplugged) → buttons=8'h00 after the frame; valid still pulses once.
- poll_req pulsed at cycle 20 of an active frame → no second latch pulse; next latch occurs 269 cycles after the previous one.
- reset asserted during LOW(4) of a Right+Up frame → pad_latch=pad_clk=buttons=0 immediately; the next poll returns 8'h90 correctly.
- Free-running with no poll_req → consecutive pad_latch rises exactly 269 cycles apart; buttons is stable between valid pulses even while the pad pattern changes mid-frame.
